// File: rtl/regfile_wb_arbiter_if.sv
// Write-back handshake bus between the two result producers, the issue logic and the
// write-back arbiter. The arbiter attaches through the slave modport.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] result_w;
  logic              result_we;
  logic              issue_valid, issue_ready;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] rd_addr, rs_addr;
  logic              rd_busy, rs_busy;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr, rd_addr, rs_addr,
    input  alu_ready, mem_ready, result, result_w, result_we,
           issue_ready, rd_busy, rs_busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           issue_valid, issue_addr, rd_addr, rs_addr,
    output alu_ready, mem_ready, result, result_w, result_we,
           issue_ready, rd_busy, rs_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs load unit) owning the register file write port,
// plus the pending-write scoreboard used by issue for RAW/WAW checks.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  logic              rr_mem;     // 0: ALU wins a tie, 1: MEM wins a tie
  logic              alu_gnt, mem_gnt, xfer, issue_fire;
  wb_req_t           win;
  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] result_w_q;
  logic              result_we_q;
  logic [NREGS-1:0]  busy, set_vec, clr_vec;

  // Grants are forced low while reset is held so nothing appears accepted.
  always_comb begin
    alu_gnt = !rst && bus.alu_valid && (!bus.mem_valid || !rr_mem);
    mem_gnt = !rst && bus.mem_valid && (!bus.alu_valid ||  rr_mem);
  end

  assign xfer          = alu_gnt | mem_gnt;
  assign win           = alu_gnt ? {bus.alu_addr, bus.alu_data} : {bus.mem_addr, bus.mem_data};
  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  assign bus.result    = result_q;
  assign bus.result_w  = result_w_q;
  assign bus.result_we = result_we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_mem      <= 1'b0;
      result_q    <= '0;
      result_w_q  <= '0;
      result_we_q <= 1'b0;
    end else begin
      result_we_q <= xfer;
      if (xfer) begin
        result_q   <= win.data;
        result_w_q <= win.addr;
      end
      if (alu_gnt)      rr_mem <= 1'b1;
      else if (mem_gnt) rr_mem <= 1'b0;
    end
  end

  // A commit to the issuing register frees it on the same edge, so issue may proceed.
  assign bus.issue_ready = !rst && (!busy[bus.issue_addr] ||
                                    (result_we_q && result_w_q == bus.issue_addr));
  assign issue_fire      = bus.issue_valid && bus.issue_ready;
  assign bus.rd_busy     = busy[bus.rd_addr];
  assign bus.rs_busy     = busy[bus.rs_addr];

  for (genvar i = 0; i < NREGS; i++) begin : g_sb
    assign set_vec[i] = issue_fire  && (bus.issue_addr == ADDR_W'(i));
    assign clr_vec[i] = result_we_q && (result_w_q     == ADDR_W'(i));
  end

  // Set dominates clear on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_vec) | set_vec;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with a behavioural register file
// fed from the write port, plus hand sequences for the reset corner cases.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  int   n_tests = 0, n_fail = 0;
  logic [15:0] rf [8];

  regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();
  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .NREGS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial for (int i = 0; i < 8; i++) rf[i] = '0;
  always @(posedge clk) if (bus.result_we) rf[bus.result_w] <= bus.result;

  // Producers must hold valid/addr/data until accepted.
  logic a_pend, m_pend;
  logic [2:0]  a_addr_q, m_addr_q;
  logic [15:0] a_data_q, m_data_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_pend <= 1'b0;
      m_pend <= 1'b0;
    end else begin
      if (a_pend) assert (bus.alu_valid && bus.alu_addr == a_addr_q && bus.alu_data == a_data_q)
        else $error("ALU producer dropped or changed a pending request");
      if (m_pend) assert (bus.mem_valid && bus.mem_addr == m_addr_q && bus.mem_data == m_data_q)
        else $error("MEM producer dropped or changed a pending request");
      a_pend   <= bus.alu_valid && !bus.alu_ready;
      m_pend   <= bus.mem_valid && !bus.mem_ready;
      a_addr_q <= bus.alu_addr;  a_data_q <= bus.alu_data;
      m_addr_q <= bus.mem_addr;  m_data_q <= bus.mem_data;
    end
  end

  typedef struct {
    logic av; logic [2:0] aa; logic [15:0] ad;
    logic mv; logic [2:0] ma; logic [15:0] md;
    logic iv; logic [2:0] ia; logic [2:0] rda; logic [2:0] rsa;
    logic ar; logic mr; logic we; logic [15:0] res; logic [2:0] w;
    logic ir; logic rdb; logic rsb;
    string nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [15:0] md,
                       input logic iv, input logic [2:0] ia,
                       input logic [2:0] rda, input logic [2:0] rsa);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    bus.issue_valid = iv; bus.issue_addr = ia;
    bus.rd_addr = rda; bus.rs_addr = rsa;
  endtask

  initial begin
    //          av aa ad     mv ma md      iv ia rd rs   ar mr we res      w  ir rdb rsb
    tbl.push_back('{1, 2, 16'd10, 1, 4, 16'd20, 0, 0, 0, 0, 1, 0, 0, 16'd0,  0, 1, 0, 0, "cont0"});
    tbl.push_back('{1, 3, 16'd11, 1, 4, 16'd20, 0, 0, 0, 0, 0, 1, 1, 16'd10, 2, 1, 0, 0, "cont1"});
    tbl.push_back('{1, 3, 16'd11, 1, 5, 16'd21, 0, 0, 0, 0, 1, 0, 1, 16'd20, 4, 1, 0, 0, "cont2"});
    tbl.push_back('{1, 7, 16'd12, 1, 5, 16'd21, 0, 0, 0, 0, 0, 1, 1, 16'd11, 3, 1, 0, 0, "cont3"});
    tbl.push_back('{1, 7, 16'd12, 0, 0, 16'd0,  0, 0, 0, 0, 1, 0, 1, 16'd21, 5, 1, 0, 0, "cont4"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  0, 0, 0, 0, 0, 0, 1, 16'd12, 7, 1, 0, 0, "cont5"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  0, 0, 0, 0, 0, 0, 0, 16'd12, 7, 1, 0, 0, "cont6"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  1, 1, 1, 0, 0, 0, 0, 16'd12, 7, 1, 0, 0, "alu0"});
    tbl.push_back('{1, 1, 16'd3,  0, 0, 16'd0,  0, 0, 1, 0, 1, 0, 0, 16'd12, 7, 1, 1, 0, "alu1"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 1, 16'd3,  1, 1, 1, 0, "alu2"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 0, 16'd3,  1, 1, 0, 0, "alu3"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  1, 5, 5, 0, 0, 0, 0, 16'd3,  1, 1, 0, 0, "waw0"});
    tbl.push_back('{0, 0, 16'd0,  1, 5, 16'h55, 1, 5, 5, 0, 0, 1, 0, 16'd3,  1, 0, 1, 0, "waw1"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  1, 5, 5, 0, 0, 0, 1, 16'h55, 5, 1, 1, 0, "waw2"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  0, 0, 5, 0, 0, 0, 0, 16'h55, 5, 1, 1, 0, "waw3"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  1, 4, 4, 2, 0, 0, 0, 16'h55, 5, 1, 0, 0, "diff0"});
    tbl.push_back('{1, 4, 16'h44, 0, 0, 16'd0,  0, 0, 4, 2, 1, 0, 0, 16'h55, 5, 1, 1, 0, "diff1"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  1, 2, 4, 2, 0, 0, 1, 16'h44, 4, 1, 1, 0, "diff2"});
    tbl.push_back('{0, 0, 16'd0,  0, 0, 16'd0,  0, 0, 4, 2, 0, 0, 0, 16'h44, 4, 1, 0, 1, "diff3"});

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].av, tbl[k].aa, tbl[k].ad, tbl[k].mv, tbl[k].ma, tbl[k].md,
            tbl[k].iv, tbl[k].ia, tbl[k].rda, tbl[k].rsa);
      #2;
      chk({tbl[k].nm, ".alu_ready"},   bus.alu_ready,   tbl[k].ar);
      chk({tbl[k].nm, ".mem_ready"},   bus.mem_ready,   tbl[k].mr);
      chk({tbl[k].nm, ".result_we"},   bus.result_we,   tbl[k].we);
      chk({tbl[k].nm, ".result"},      bus.result,      tbl[k].res);
      chk({tbl[k].nm, ".result_w"},    bus.result_w,    tbl[k].w);
      chk({tbl[k].nm, ".issue_ready"}, bus.issue_ready, tbl[k].ir);
      chk({tbl[k].nm, ".rd_busy"},     bus.rd_busy,     tbl[k].rdb);
      chk({tbl[k].nm, ".rs_busy"},     bus.rs_busy,     tbl[k].rsb);
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rf1", rf[1], 16'd3);
    chk("rf2", rf[2], 16'd10);
    chk("rf4", rf[4], 16'h44);
    chk("rf5", rf[5], 16'h55);
    chk("rf7", rf[7], 16'd12);

    // Asynchronous reset with the clock stopped; busy[2], busy[5] set and the pointer on MEM.
    @(negedge clk);
    drive(1, 6, 16'h66, 0, 0, 0, 0, 0, 2, 5);
    @(negedge clk);
    clk_en = 1'b0;
    drive(1, 3, 16'h33, 0, 0, 0, 1, 2, 2, 5);
    #2;
    chk("pre_rst.result_we", bus.result_we, 1'b1);
    chk("pre_rst.rd_busy",   bus.rd_busy,   1'b1);
    rst = 1'b1;
    #1;
    chk("rst.result_we",   bus.result_we,   1'b0);
    chk("rst.result",      bus.result,      16'd0);
    chk("rst.result_w",    bus.result_w,    3'd0);
    chk("rst.alu_ready",   bus.alu_ready,   1'b0);
    chk("rst.mem_ready",   bus.mem_ready,   1'b0);
    chk("rst.issue_ready", bus.issue_ready, 1'b0);
    chk("rst.rd_busy",     bus.rd_busy,     1'b0);
    chk("rst.rs_busy",     bus.rs_busy,     1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    drive(1, 0, 16'd1, 1, 3, 16'd2, 0, 0, 0, 0);
    #2;
    chk("post_rst_cont.alu_ready", bus.alu_ready, 1'b1);
    chk("post_rst_cont.mem_ready", bus.mem_ready, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 1, 3, 16'd2, 0, 0, 0, 0);
    #2;
    chk("post_rst_cont2.mem_ready", bus.mem_ready, 1'b1);

    // Reset between acceptance and commit of a load write to reg 6.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
    #2;
    chk("mid.issue_ready", bus.issue_ready, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 1, 6, 16'hBEEF, 0, 0, 6, 0);
    #2;
    chk("mid.mem_ready", bus.mem_ready, 1'b1);
    chk("mid.rd_busy",   bus.rd_busy,   1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    #2;
    chk("mid.result_we", bus.result_we, 1'b1);
    chk("mid.result_w",  bus.result_w,  3'd6);
    rst = 1'b1;
    #1;
    chk("mid_rst.result_we", bus.result_we, 1'b0);
    chk("mid_rst.rd_busy",   bus.rd_busy,   1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1, 1, 16'd7, 1, 2, 16'd8, 0, 0, 6, 0);
    #2;
    chk("mid_after.rf6",       rf[6],         16'd0);
    chk("mid_after.rd_busy",   bus.rd_busy,   1'b0);
    chk("mid_after.alu_ready", bus.alu_ready, 1'b1);
    chk("mid_after.mem_ready", bus.mem_ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sole owner of the register file write port (`result`, `result_w`) for the 8 x 16-bit register file.
- Arbitrates write-back requests from two producers, the ALU and the load unit, using round-robin. Each producer uses a valid/ready handshake.
- Registers the winning write and drives it to the register file one cycle later.
- Keeps an 8-bit pending-write scoreboard. Issue logic uses it to detect RAW hazards on `rd_addr`/`rs_addr` and to block WAW issue.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NREGS, 8, number of registers (equals 2**ADDR_W)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load-unit write-back request
- mem_ready  out  1  load request accepted this cycle
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- result  out  DATA_W  write data to the register file
- result_w  out  ADDR_W  write address to the register file
- result_we  out  1  register file write enable
- issue_valid  in  1  decoder issues an instruction that writes issue_addr
- issue_addr  in  ADDR_W  destination of the issuing instruction
- issue_ready  out  1  issue permitted (no pending write to issue_addr)
- rd_addr  in  ADDR_W  read address, shared with the register file
- rs_addr  in  ADDR_W  read address, shared with the register file
- rd_busy  out  1  register rd_addr has a pending write
- rs_busy  out  1  register rs_addr has a pending write

Behaviour:
- Reset (asynchronous; takes effect immediately, regardless of clk):
  - result=0, result_w=0, result_we=0.
  - busy[7:0]=0.
  - Round-robin pointer selects ALU.
  - Any transfer accepted but not yet written is dropped. Its busy bit is cleared along with the rest.
- Arbitration (combinational in cycle N):
  - Only alu_valid high: alu_ready=1.
  - Only mem_valid high: mem_ready=1.
  - Both high: grant the source the pointer selects; the other sees ready=0.
  - Never both ready=1 in the same cycle.
  - Neither valid: both ready=0, pointer unchanged.
- Pointer update: after any grant, the pointer moves to the source that was not granted. Under continuous contention the grants therefore alternate ALU, MEM, ALU, ...
- Producer rule: once valid is raised, it is held with addr/data stable until ready. A bench assertion checks this; the RTL does not repair violations.
- Write stage:
  - A transfer in cycle N (valid & ready) loads result/result_w at edge N+1, with result_we=1 during cycle N+1.
  - The register file writes at edge N+2.
  - Without a transfer, result_we=0 the next cycle; result/result_w hold their last values.
  - Throughput is 1 write per cycle.
- Scoreboard:
  - An edge with issue_valid & issue_ready sets busy[issue_addr].
  - An edge with result_we clears busy[result_w], the same edge on which the register file commits the data. A read after that edge therefore sees the new value together with busy=0.
  - Set and clear on the same address at the same edge: set wins, so the bit stays 1.
  - Set and clear on different addresses apply independently.
- Combinational outputs:
  - issue_ready = !busy[issue_addr] | (result_we & result_w==issue_addr).
  - rd_busy = busy[rd_addr]; rs_busy = busy[rs_addr]. There is no bypass.
- Write-back to a register with busy=0 is legal: the data is written and busy stays 0.
- Register 0 has no special treatment.

Test Plan:
- Reset values: assert rst mid-cycle with clk stopped -> result_we=0, result=0, busy=0, all ready=0 immediately.
- Single ALU write: issue_valid, issue_addr=1; next cycle alu_valid, alu_addr=1, alu_data=16'd3 ->
  - alu_ready=1 in that cycle; result=3, result_w=1, result_we=1 the next cycle;
  - rd_busy (rd_addr=1) high until the commit edge, then low; the register file reads 3.
- Contention: alu_valid and mem_valid held for 4 cycles (ALU data 10,11; MEM data 20,21, all to distinct regs) -> grant order ALU, MEM, ALU, MEM; result sequence 10,20,11,21 with result_we high for 4 consecutive cycles.
- WAW block: busy[5]=1; issue_valid, issue_addr=5 -> issue_ready=0. In the cycle result_we=1 with result_w=5 -> issue_ready=1; issue accepted, busy[5] stays 1 after the edge.
- Same-edge issue/clear on different regs: issue to reg 2 while result_w=4 commits -> busy[2]=1, busy[4]=0 after the edge.
- Reset mid-operation: accept MEM write to reg 6 (busy[6]=1), assert rst before the write stage -> no write to reg 6, busy[6]=0. After release, the first contended grant goes to ALU.
